// File: rtl/spi_reg_bank.sv
// SPI-slave register bank, oversampled on the system clock (SPI mode 0).
// Command byte {op[1:0], index[5:0]} followed by DW data bits; update applied on cs_n release.
module spi_reg_bank #(
  parameter int unsigned   NREG    = 4,
  parameter int unsigned   DW      = 8,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic [NREG*DW-1:0]   regs,
  output logic                 wr_strobe,
  output logic [5:0]           wr_addr,
  output logic                 frame_err
);

  localparam int unsigned CW        = 6;
  localparam logic [CW-1:0] FRAME_LEN = CW'(8 + DW);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CMD_LAST  = CW'(7);
  localparam logic [6:0]    NREG_L    = 7'(NREG);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_COMMIT} state_t;

  state_t r_state, w_state_nxt;

  logic [1:0]    r_sclk_s, r_cs_s, r_mosi_s;
  logic          r_sclk_d, r_cs_d;
  logic          r_armed, r_pend;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_cmd;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_sh_out;
  logic          r_miso, r_oe, r_strobe, r_err;
  logic [5:0]    r_addr;
  logic [DW-1:0] r_bank [NREG];

  logic          w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi;
  logic          w_start, w_commit, w_reject, w_len_ok, w_idx_ok;
  logic [7:0]    w_cmd_shift;
  logic [5:0]    w_sel;
  logic [1:0]    w_op;
  logic [DW-1:0] w_sel_val, w_upd;

  // 2-FF synchronisers; cs_n chain resets low so a frame in progress at reset release is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s <= '0;
      r_cs_s   <= '0;
      r_mosi_s <= '0;
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], sclk};
      r_cs_s   <= {r_cs_s[0], cs_n};
      r_mosi_s <= {r_mosi_s[0], mosi};
      r_sclk_d <= r_sclk_s[1];
      r_cs_d   <= r_cs_s[1];
    end
  end

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_d;
  assign w_cs_rise   = r_cs_s[1] & ~r_cs_d;
  assign w_cs_fall   = ~r_cs_s[1] & r_cs_d;
  assign w_mosi      = r_mosi_s[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall || r_pend) begin
          w_state_nxt = S_CMD;
          w_start     = 1'b1;
        end
      end
      S_CMD: begin
        if (w_cs_rise)                             w_state_nxt = S_COMMIT;
        else if (w_sclk_rise && r_cnt == CMD_LAST) w_state_nxt = S_DATA;
      end
      S_DATA:   if (w_cs_rise) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Register select: the incoming index on the 8th rise, the latched one afterwards
  always_comb begin
    w_cmd_shift = {r_cmd[6:0], w_mosi};
    w_sel       = (r_state == S_CMD) ? w_cmd_shift[5:0] : r_cmd[5:0];
    w_sel_val   = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (w_sel == 6'(i)) w_sel_val = r_bank[i];
    end
    w_op     = r_cmd[7:6];
    w_idx_ok = {1'b0, r_cmd[5:0]} < NREG_L;
    w_len_ok = (r_cnt == FRAME_LEN);
    case (w_op)
      2'b01:   w_upd = r_data;
      2'b10:   w_upd = w_sel_val | r_data;
      2'b11:   w_upd = w_sel_val & ~r_data;
      default: w_upd = w_sel_val;
    endcase
    w_commit = (r_state == S_COMMIT) && w_len_ok && w_idx_ok && (w_op != 2'b00);
    w_reject = (r_state == S_COMMIT) && (!w_len_ok || ((w_op != 2'b00) && !w_idx_ok));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_cmd    <= '0;
      r_data   <= '0;
      r_sh_out <= '0;
      r_miso   <= 1'b0;
      r_oe     <= 1'b0;
      r_armed  <= 1'b0;
      r_pend   <= 1'b0;
      r_strobe <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      for (int unsigned i = 0; i < NREG; i++) r_bank[i] <= RST_VAL;
    end else begin
      r_strobe <= w_commit;
      r_err    <= w_reject;
      if (r_cs_s[1]) r_armed <= 1'b1;
      r_oe     <= r_armed & ~r_cs_s[1];
      r_pend   <= (r_state == S_COMMIT) & w_cs_fall;

      if (w_start) begin
        r_cnt    <= '0;
        r_cmd    <= '0;
        r_data   <= '0;
        r_sh_out <= '0;
      end else if ((r_state == S_CMD || r_state == S_DATA) && w_sclk_rise) begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 6'd1;
        if (r_state == S_CMD) begin
          r_cmd <= w_cmd_shift;
          if (r_cnt == CMD_LAST) r_sh_out <= w_sel_val;
        end else begin
          r_data <= (r_data << 1) | DW'(w_mosi);
        end
      end

      // Shadow empties to zero, so miso drops to 0 once DW bits have gone out
      if (r_state == S_DATA && w_sclk_fall) begin
        r_miso   <= r_sh_out[DW-1];
        r_sh_out <= r_sh_out << 1;
      end else if (r_state != S_DATA) begin
        r_miso <= 1'b0;
      end

      if (w_commit) begin
        r_addr <= r_cmd[5:0];
        for (int unsigned i = 0; i < NREG; i++) begin
          if (r_cmd[5:0] == 6'(i)) r_bank[i] <= w_upd;
        end
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_out
    assign regs[g*DW +: DW] = r_bank[g];
  end

  assign miso      = r_miso;
  assign miso_oe   = r_oe;
  assign wr_strobe = r_strobe;
  assign wr_addr   = r_addr;
  assign frame_err = r_err;

endmodule
